// File: rtl/seq_booth_multiplier_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier:
// FSM state encoding and the default operand width.
package seq_booth_multiplier_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/seq_booth_multiplier_ripple_adder.sv
// Ripple-carry adder built from a chain of full-adder cells.
// Purely combinational; carry propagates LSB to MSB.
module ripple_adder #(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/seq_booth_multiplier.sv
// Sequential radix-2 Booth multiplier, signed or unsigned operands, one step per cycle.
// Latency WIDTH+1 cycles from accept to done; start is ignored while busy.
module seq_booth_multiplier
  import seq_booth_multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_op,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int EW = WIDTH + 1;
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] ITERS = CW'(EW);

  state_t          state;
  logic [EW-1:0]   a_reg;
  logic [EW-1:0]   q_reg;
  logic [EW-1:0]   m_reg;
  logic            q_m1;
  logic [CW-1:0]   cnt;

  logic [EW-1:0]   add_b;
  logic            add_cin;
  logic [EW-1:0]   add_sum;
  logic            unused_cout;
  logic [EW-1:0]   next_a;
  logic [EW-1:0]   next_q;
  logic [EW-1:0]   m_ext;
  logic [EW-1:0]   q_ext;

  // One extra bit lets unsigned operands ride through the signed Booth recoding.
  assign m_ext = {signed_op & multiplicand[WIDTH-1], multiplicand};
  assign q_ext = {signed_op & multiplier[WIDTH-1],   multiplier};

  // Booth recoding selects +M, -M (as ~M + 1) or zero into the single adder.
  always_comb begin
    add_b   = '0;
    add_cin = 1'b0;
    case ({q_reg[0], q_m1})
      2'b01: add_b = m_reg;
      2'b10: begin
        add_b   = ~m_reg;
        add_cin = 1'b1;
      end
      default: add_b = '0;
    endcase
  end

  ripple_adder #(
    .WIDTH (EW)
  ) u_adder (
    .a    (a_reg),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (unused_cout)
  );

  // Arithmetic right shift of {A, Q, q_m1}.
  assign next_a = {add_sum[EW-1], add_sum[EW-1:1]};
  assign next_q = {add_sum[0], q_reg[EW-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      a_reg   <= '0;
      q_reg   <= '0;
      m_reg   <= '0;
      q_m1    <= 1'b0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_RUN;
            a_reg <= '0;
            q_reg <= q_ext;
            m_reg <= m_ext;
            q_m1  <= 1'b0;
            cnt   <= ITERS;
          end
        end
        ST_RUN: begin
          a_reg <= next_a;
          q_reg <= next_q;
          q_m1  <= q_reg[0];
          cnt   <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state   <= ST_DONE;
            product <= {next_a[WIDTH-2:0], next_q};
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Directed and randomized checks of seq_booth_multiplier at WIDTH=8 and WIDTH=11.
module tb_seq_booth_multiplier;

  logic        clk;
  logic        rst_n;

  logic        start8, sop8;
  logic [7:0]  m8, q8;
  logic        busy8, done8;
  logic [15:0] prod8;

  logic        start11, sop11;
  logic [10:0] m11, q11;
  logic        busy11, done11;
  logic [21:0] prod11;

  int n_checks = 0;
  int n_fail   = 0;

  seq_booth_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .signed_op(sop8),
    .multiplicand(m8), .multiplier(q8),
    .busy(busy8), .done(done8), .product(prod8)
  );

  seq_booth_multiplier #(.WIDTH(11)) dut11 (
    .clk(clk), .rst_n(rst_n), .start(start11), .signed_op(sop11),
    .multiplicand(m11), .multiplier(q11),
    .busy(busy11), .done(done11), .product(prod11)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge; returns at the negedge where done is seen (or budget exhausted).
  task automatic do_op8(input bit s, input logic [7:0] m, input logic [7:0] q, output int edges);
    sop8 = s; m8 = m; q8 = q; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    edges = 0;
    while (done8 !== 1'b1 && edges < 40) begin
      @(posedge clk); edges++; @(negedge clk);
    end
  endtask

  task automatic do_op11(input bit s, input logic [10:0] m, input logic [10:0] q, output int edges);
    sop11 = s; m11 = m; q11 = q; start11 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start11 = 1'b0;
    edges = 0;
    while (done11 !== 1'b1 && edges < 40) begin
      @(posedge clk); edges++; @(negedge clk);
    end
  endtask

  function automatic logic [21:0] ref11(bit s, logic [10:0] m, logic [10:0] q);
    longint a, b;
    a = s ? longint'($signed(m)) : longint'({53'd0, m});
    b = s ? longint'($signed(q)) : longint'({53'd0, q});
    return 22'(a * b);
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    start8 = 0; sop8 = 0; m8 = 0; q8 = 0;
    start11 = 0; sop11 = 0; m11 = 0; q11 = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy8, done8} !== 2'b00) begin n_fail++; $display("FAIL reset_flags8: got %b expected 00", {busy8, done8}); end
    n_checks++;
    if (prod8 !== 16'h0000) begin n_fail++; $display("FAIL reset_prod8: got %h expected 0000", prod8); end
    n_checks++;
    if ({busy11, done11, prod11} !== 24'h0) begin n_fail++; $display("FAIL reset_dut11: got %h expected 000000", {busy11, done11, prod11}); end
    rst_n = 1'b1;
  endtask

  task automatic test_signed_corner;
    int e;
    // First start right after reset release: accepted on the first rising edge.
    do_op8(1'b1, 8'h80, 8'h80, e);
    n_checks++;
    if (e !== 9) begin n_fail++; $display("FAIL corner_latency: got %0d expected 9", e); end
    n_checks++;
    if (prod8 !== 16'h4000) begin n_fail++; $display("FAIL corner_prod: got %h expected 4000", prod8); end
    n_checks++;
    if (busy8 !== 1'b1) begin n_fail++; $display("FAIL busy_in_done: got %b expected 1", busy8); end
    @(negedge clk);
    n_checks++;
    if ({busy8, done8} !== 2'b00) begin n_fail++; $display("FAIL done_one_cycle: got %b expected 00", {busy8, done8}); end
    n_checks++;
    if (prod8 !== 16'h4000) begin n_fail++; $display("FAIL prod_hold: got %h expected 4000", prod8); end
  endtask

  task automatic test_modes;
    int e;
    do_op8(1'b0, 8'hFF, 8'hFF, e); @(negedge clk);
    n_checks++;
    if (prod8 !== 16'hFE01) begin n_fail++; $display("FAIL unsigned_ff: got %h expected fe01", prod8); end
    do_op8(1'b1, 8'hFF, 8'hFF, e); @(negedge clk);
    n_checks++;
    if (prod8 !== 16'h0001) begin n_fail++; $display("FAIL signed_m1m1: got %h expected 0001", prod8); end
    do_op8(1'b1, 8'hFF, 8'h01, e); @(negedge clk);
    n_checks++;
    if (prod8 !== 16'hFFFF) begin n_fail++; $display("FAIL signed_m1p1: got %h expected ffff", prod8); end
    do_op8(1'b1, 8'h00, 8'hB3, e); @(negedge clk);
    n_checks++;
    if (prod8 !== 16'h0000) begin n_fail++; $display("FAIL zero_times: got %h expected 0000", prod8); end
    do_op8(1'b1, 8'h7F, 8'h80, e); @(negedge clk);
    n_checks++;
    if (prod8 !== 16'hC080) begin n_fail++; $display("FAIL signed_127x-128: got %h expected c080", prod8); end
    do_op8(1'b0, 8'h80, 8'h02, e); @(negedge clk);
    n_checks++;
    if (prod8 !== 16'h0100) begin n_fail++; $display("FAIL unsigned_128x2: got %h expected 0100", prod8); end
  endtask

  task automatic test_start_during_run;
    int done_cnt = 0;
    sop8 = 1'b1; m8 = 8'd5; q8 = 8'd7; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 3) begin start8 = 1'b1; sop8 = 1'b0; m8 = 8'd100; q8 = 8'd100; end
      else start8 = 1'b0;
      if (done8 === 1'b1) done_cnt++;
      @(posedge clk); @(negedge clk);
    end
    n_checks++;
    if (done_cnt !== 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d expected 1", done_cnt); end
    n_checks++;
    if (prod8 !== 16'h0023) begin n_fail++; $display("FAIL ignore_prod: got %h expected 0023", prod8); end
  endtask

  task automatic test_reset_mid_run;
    int e;
    int done_cnt = 0;
    sop8 = 1'b1; m8 = 8'd3; q8 = 8'hFB; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) begin @(posedge clk); @(negedge clk); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy8, done8} !== 2'b00) begin n_fail++; $display("FAIL midrun_flags: got %b expected 00", {busy8, done8}); end
    n_checks++;
    if (prod8 !== 16'h0000) begin n_fail++; $display("FAIL midrun_prod: got %h expected 0000", prod8); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8 === 1'b1) done_cnt++;
    end
    n_checks++;
    if (done_cnt !== 0) begin n_fail++; $display("FAIL aborted_done: got %0d expected 0", done_cnt); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_op8(1'b1, 8'hFD, 8'd5, e);
    n_checks++;
    if (e !== 9 || prod8 !== 16'hFFF1) begin n_fail++; $display("FAIL after_reset: got lat %0d prod %h expected lat 9 prod fff1", e, prod8); end
  endtask

  task automatic test_back_to_back;
    int e1, e2;
    do_op8(1'b0, 8'd12, 8'd11, e1);
    @(negedge clk);
    n_checks++;
    if (busy8 !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %b expected 0", busy8); end
    do_op8(1'b1, 8'hF6, 8'd10, e2);
    n_checks++;
    if (e2 !== 9 || prod8 !== 16'hFF9C) begin n_fail++; $display("FAIL b2b_second: got lat %0d prod %h expected lat 9 prod ff9c", e2, prod8); end
    @(negedge clk);
  endtask

  task automatic test_width11;
    int e;
    logic [10:0] m, q;
    logic [21:0] exp_p;
    do_op11(1'b1, 11'h400, 11'h400, e);
    n_checks++;
    if (e !== 12) begin n_fail++; $display("FAIL w11_latency: got %0d expected 12", e); end
    n_checks++;
    if (prod11 !== 22'h100000) begin n_fail++; $display("FAIL w11_corner: got %h expected 100000", prod11); end
    @(negedge clk);
    do_op11(1'b0, 11'h7FF, 11'h7FF, e);
    n_checks++;
    if (prod11 !== 22'h3FF001) begin n_fail++; $display("FAIL w11_unsigned_max: got %h expected 3ff001", prod11); end
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      m = 11'($urandom);
      q = 11'($urandom);
      exp_p = ref11(i[0], m, q);
      do_op11(i[0], m, q, e);
      n_checks++;
      if (e !== 12 || prod11 !== exp_p) begin
        n_fail++;
        $display("FAIL w11_random mode=%0d m=%h q=%h: got lat %0d prod %h expected lat 12 prod %h", i[0], m, q, e, prod11, exp_p);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_signed_corner();
    test_modes();
    test_start_during_run();
    test_reset_mid_run();
    test_back_to_back();
    test_width11();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_booth_multiplier.md
SEQ_BOOTH_MULTIPLIER -- requirements
Module: seq_booth_multiplier

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 4..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request; sampled only while busy=0.
REQ-005 signed_op  input  1  1 = two's-complement operands, 0 = unsigned operands; captured with start.
REQ-006 multiplicand  input  WIDTH  operand M; captured with start.
REQ-007 multiplier  input  WIDTH  operand Q; captured with start.
REQ-008 busy  output  1  high in RUN and DONE states.
REQ-009 done  output  1  one-cycle pulse; product valid.
REQ-010 product  output  2*WIDTH  result; held from done until the next accepted start.

Function
REQ-011 FSM states IDLE, RUN, DONE; IDLE->RUN on start=1 with busy=0; RUN->DONE when the iteration count reaches zero; DONE->IDLE unconditionally after one cycle.
REQ-012 On accept, operands are extended to WIDTH+1 bits: sign-extended if signed_op=1, zero-extended if signed_op=0.
REQ-013 Datapath registers: accumulator A (WIDTH+1 bits, cleared on accept), Q (WIDTH+1 bits, loaded with the extended multiplier), q_m1 (1 bit, cleared on accept), counter loaded with WIDTH+1.
REQ-014 Each RUN cycle performs one radix-2 Booth step: {Q[0],q_m1}=01 -> A+M; 10 -> A-M; 00/11 -> A unchanged; then arithmetic right shift of {A,Q,q_m1} by one; counter decrements.
REQ-015 Subtraction is done as A + ~M with carry-in 1 through the same adder; no second adder.
REQ-016 RUN lasts exactly WIDTH+1 cycles; done is high for the single cycle following the edge that performs the last step (WIDTH+1 edges after the accepting edge).
REQ-017 product is updated from the low 2*WIDTH bits of {A,Q} on the edge entering DONE; otherwise it holds.
REQ-018 start while busy=1 (RUN or DONE) is ignored; operands and signed_op changes during busy have no effect.
REQ-019 start asserted in the IDLE cycle immediately after DONE is accepted normally (back-to-back throughput WIDTH+3 cycles).
REQ-020 Adder carry-out is discarded; no overflow flag; the 2*WIDTH-bit result is exact for all operand values in both modes.

Reset
REQ-021 rst_n=0 immediately forces state IDLE, busy=0, done=0, product=0, and clears A, Q, q_m1, counter.
REQ-022 Reset asserted mid-RUN aborts the operation; no done pulse occurs for the aborted operation.
REQ-023 First start is accepted on the first rising edge after rst_n deasserts.

Structure
REQ-024 A shared package holds the state enumeration (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-025 One sub-module: ripple_adder, parametrised to WIDTH+1 bits, with A, B, Cin, Sum, Cout ports, built from FA cells; instantiated once.
REQ-026 Counter width is $clog2(WIDTH+2) bits.

Verification
REQ-027 WIDTH=8, signed_op=1, M=-128, Q=-128 -> done after 9 RUN cycles, product=16'h4000.
REQ-028 WIDTH=8, signed_op=0, M=255, Q=255 -> product=16'hFE01; signed_op=1 with same bits (-1*-1) -> product=16'h0001.
REQ-029 WIDTH=8, signed_op=1, M=-1, Q=1 -> product=16'hFFFF; M=0, Q=-77 -> product=16'h0000.
REQ-030 Start pulsed with new operands during RUN -> ignored, product equals the first operation, exactly one done pulse.
REQ-031 rst_n dropped at RUN cycle 4 -> busy=0, done=0, product=0 at once; new start after release gives correct result.
REQ-032 WIDTH=11, signed_op=1, M=-1024, Q=-1024 -> product=22'h100000, done 12 edges after accept; random regression vs. reference model, both modes.
